// File: rtl/exc_seq.sv
// rtl/exc_seq.sv - prioritised maskable exception sequencer for the multicycle MIPS datapath (optional EXC_CAUSE_EN adds exc_cause)
module exc_seq #(
  parameter int N_SRC    = 3,
  parameter int VEC_BASE = 253,
  parameter int PC_DEC   = 4,
  parameter int IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] exc_req,
  input  logic [N_SRC-1:0] exc_mask,
  output logic             busy,
  output logic             exc_done,
  output logic [7:0]       vec_addr,
  output logic [1:0]       mux_mem,
  output logic             epc_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       mux_to_pc
`ifdef EXC_CAUSE_EN
  ,
  output logic [IDX_W-1:0] exc_cause
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    LOAD  = 3'd2,
    WRPC  = 3'd3,
    CLOSE = 3'd4
  } state_t;

  // Vector addresses wrap inside the 8-bit memory space.
  localparam logic [7:0] VEC_BASE8 = 8'(VEC_BASE);

  // The datapath constant input for EPC must be a usable 8-bit displacement.
  if (PC_DEC < 1 || PC_DEC > 255) begin : g_bad_pc_dec
    $error("exc_seq: PC_DEC out of range");
  end

  state_t           state, state_nx;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eff;
  logic [N_SRC-1:0] take;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic             start;

  assign eff   = pending | (exc_req & ~exc_mask);
  assign start = (state == IDLE) && found;
  assign take  = start ? (N_SRC'(1) << sel_idx) : '0;

  // Priority encoder: lowest set index of eff wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eff[i]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // State, pending set and current index; the source being taken is cleared on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      cur_idx <= '0;
    end else begin
      state   <= state_nx;
      pending <= eff & ~take;
      if (start) begin
        cur_idx <= sel_idx;
      end
    end
  end

`ifdef EXC_CAUSE_EN
  logic [IDX_W-1:0] cause;

  // Cause latches the serviced index when a sequence starts and holds until the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cause <= '0;
    end else if (start) begin
      cause <= sel_idx;
    end
  end

  assign exc_cause = (state != IDLE) ? cause : '0;
`endif

  // Next-state and Moore control decode; everything idles at zero.
  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    exc_done    = 1'b0;
    vec_addr    = 8'd0;
    mux_mem     = 2'b00;
    epc_write   = 1'b0;
    mdr_write   = 1'b0;
    pc_write    = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 3'b000;
    alu_control = 3'b000;
    mux_to_pc   = 2'b00;
    if (state != IDLE) begin
      busy     = 1'b1;
      vec_addr = VEC_BASE8 + 8'(cur_idx);
    end
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = SAVE;
        end
      end
      SAVE: begin
        mux_mem     = 2'b10;
        alu_src_a   = 2'b00;
        alu_src_b   = 3'b001;
        alu_control = 3'b010;
        epc_write   = 1'b1;
        state_nx    = LOAD;
      end
      LOAD: begin
        mux_mem   = 2'b10;
        mdr_write = 1'b1;
        state_nx  = WRPC;
      end
      WRPC: begin
        alu_src_a   = 2'b01;
        alu_control = 3'b000;
        mux_to_pc   = 2'b00;
        pc_write    = 1'b1;
        state_nx    = CLOSE;
      end
      CLOSE: begin
        exc_done = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_seq.sv
// tb/tb_exc_seq.sv - scoreboard testbench for exc_seq (default and wrapped vector base instances)
module tb_exc_seq;

  logic       clock;
  logic       reset;
  logic [2:0] exc_req0, exc_mask0, exc_req1, exc_mask1;

  logic       busy0, exc_done0, epc_write0, mdr_write0, pc_write0;
  logic [7:0] vec_addr0;
  logic [1:0] mux_mem0, alu_src_a0, mux_to_pc0;
  logic [2:0] alu_src_b0, alu_control0;
  logic       busy1, exc_done1, epc_write1, mdr_write1, pc_write1;
  logic [7:0] vec_addr1;
  logic [1:0] mux_mem1, alu_src_a1, mux_to_pc1;
  logic [2:0] alu_src_b1, alu_control1;
`ifdef EXC_CAUSE_EN
  logic [1:0] exc_cause0, exc_cause1;
`endif

  exc_seq #(.N_SRC(3), .VEC_BASE(253), .PC_DEC(4)) u_dut (
    .clock(clock), .reset(reset), .exc_req(exc_req0), .exc_mask(exc_mask0),
    .busy(busy0), .exc_done(exc_done0), .vec_addr(vec_addr0), .mux_mem(mux_mem0),
    .epc_write(epc_write0), .mdr_write(mdr_write0), .pc_write(pc_write0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_control(alu_control0),
    .mux_to_pc(mux_to_pc0)
`ifdef EXC_CAUSE_EN
    , .exc_cause(exc_cause0)
`endif
  );

  exc_seq #(.N_SRC(3), .VEC_BASE(255), .PC_DEC(4)) u_wrap (
    .clock(clock), .reset(reset), .exc_req(exc_req1), .exc_mask(exc_mask1),
    .busy(busy1), .exc_done(exc_done1), .vec_addr(vec_addr1), .mux_mem(mux_mem1),
    .epc_write(epc_write1), .mdr_write(mdr_write1), .pc_write(pc_write1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_control(alu_control1),
    .mux_to_pc(mux_to_pc1)
`ifdef EXC_CAUSE_EN
    , .exc_cause(exc_cause1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  wire [23:0] out0 = {exc_done0, vec_addr0, mux_mem0, epc_write0, mdr_write0, pc_write0,
                      alu_src_a0, alu_src_b0, alu_control0, mux_to_pc0};
  wire [23:0] out1 = {exc_done1, vec_addr1, mux_mem1, epc_write1, mdr_write1, pc_write1,
                      alu_src_a1, alu_src_b1, alu_control1, mux_to_pc1};

  typedef struct packed {
    logic [23:0] v;
    logic [1:0]  cause;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  // Hand-written control word per sequence state: 1=SAVE 2=LOAD 3=WRPC 4=CLOSE.
  function automatic logic [23:0] exp_vec(input int st, input logic [7:0] vec);
    case (st)
      1: return {1'b0, vec, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 3'b001, 3'b010, 2'b00};
      2: return {1'b0, vec, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00};
      3: return {1'b0, vec, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 3'b000, 2'b00};
      4: return {1'b1, vec, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00};
      default: return 24'h0;
    endcase
  endfunction

  task automatic push_state(input int dut, input int st, input logic [7:0] vec, input logic [1:0] cause);
    exp_t e;
    e.v     = exp_vec(st, vec);
    e.cause = cause;
    if (dut == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic push_seq(input int dut, input logic [7:0] vec, input logic [1:0] cause);
    for (int s = 1; s <= 4; s++) push_state(dut, s, vec, cause);
  endtask

  // Called just after a rising edge: holds r for exactly one sampling edge.
  task automatic pulse(input logic [2:0] r);
    exc_req0 = r;
    @(posedge clock);
    #1;
    exc_req0 = 3'b000;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy0, out0} !== 25'h0 || {busy1, out1} !== 25'h0) begin
      errors++;
      $display("FAIL %s: dut outputs=%h wrap outputs=%h, required all zero", name, {busy0, out0}, {busy1, out1});
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || busy0 || busy1) begin
      errors++;
      $display("FAIL %s: not drained, pending expected=%0d/%0d busy=%0b/%0b, required 0", name, q0.size(), q1.size(), busy0, busy1);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Monitor for the default instance: every busy cycle must match the next expected state.
  always @(negedge clock) begin
    if (!reset) begin
      prev_done0 = 1'b0;
    end else begin
      if (prev_done0) begin
        checks++;
        if (busy0) begin
          errors++;
          $display("FAIL gap0: busy=%0b in cycle after CLOSE, required 0", busy0);
        end
      end
      if (busy0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected0: busy with outputs=%h, required idle", out0);
        end else begin
          e0 = q0.pop_front();
          if (out0 !== e0.v) begin
            errors++;
            $display("FAIL ctrl0: outputs=%h, required %h", out0, e0.v);
          end
`ifdef EXC_CAUSE_EN
          checks++;
          if (exc_cause0 !== e0.cause) begin
            errors++;
            $display("FAIL cause0: exc_cause=%0d, required %0d", exc_cause0, e0.cause);
          end
`endif
        end
      end
      prev_done0 = exc_done0;
    end
  end

  // Monitor for the wrapped vector base instance.
  always @(negedge clock) begin
    if (!reset) begin
      prev_done1 = 1'b0;
    end else begin
      if (prev_done1) begin
        checks++;
        if (busy1) begin
          errors++;
          $display("FAIL gap1: busy=%0b in cycle after CLOSE, required 0", busy1);
        end
      end
      if (busy1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected1: busy with outputs=%h, required idle", out1);
        end else begin
          e1 = q1.pop_front();
          if (out1 !== e1.v) begin
            errors++;
            $display("FAIL ctrl1: outputs=%h, required %h", out1, e1.v);
          end
`ifdef EXC_CAUSE_EN
          checks++;
          if (exc_cause1 !== e1.cause) begin
            errors++;
            $display("FAIL cause1: exc_cause=%0d, required %0d", exc_cause1, e1.cause);
          end
`endif
        end
      end
      prev_done1 = exc_done1;
    end
  end

  initial begin
    int busy_cnt;
    reset     = 1'b0;
    exc_req0  = 3'b000;
    exc_mask0 = 3'b000;
    exc_req1  = 3'b000;
    exc_mask1 = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset asserted mid-sequence during LOAD: only SAVE and LOAD are ever seen.
    push_state(0, 1, 8'd253, 2'd0);
    push_state(0, 2, 8'd253, 2'd0);
    pulse(3'b001);
    @(posedge clock);
    #7;
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clock);
    #1;
    check_zero("reset_hold");
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_zero("post_reset_idle");
    wait_drain("drain_reset");

    // Single overflow.
    push_seq(0, 8'd253, 2'd0);
    pulse(3'b001);
    wait_drain("drain_single");

    // Two simultaneous requests served in index order.
    push_seq(0, 8'd254, 2'd1);
    push_seq(0, 8'd255, 2'd2);
    pulse(3'b110);
    wait_drain("drain_priority");

    // Masked overflow never starts a sequence.
    exc_mask0 = 3'b001;
    exc_req0  = 3'b001;
    busy_cnt  = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (busy0) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 0) begin
      errors++;
      $display("FAIL mask_busy: busy cycles=%0d, required 0", busy_cnt);
    end
    push_seq(0, 8'd255, 2'd2);
    exc_req0 = 3'b100;
    @(posedge clock);
    #1;
    exc_req0  = 3'b000;
    exc_mask0 = 3'b000;
    wait_drain("drain_mask");

    // Late arrivals: source 2 during SAVE of source 1, source 0 during WRPC.
    push_seq(0, 8'd254, 2'd1);
    push_seq(0, 8'd253, 2'd0);
    push_seq(0, 8'd255, 2'd2);
    pulse(3'b010);
    pulse(3'b100);
    @(posedge clock);
    #1;
    pulse(3'b001);
    wait_drain("drain_late");

    // Vector address wraps: 255 + 1 = 0.
    push_seq(1, 8'd0, 2'd1);
    exc_req1 = 3'b010;
    @(posedge clock);
    #1;
    exc_req1 = 3'b000;
    wait_drain("drain_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
